// File: rtl/router_pkt_tx_if.sv
// Host-side handshake and router byte stream for router_pkt_tx.
// The master modport is the host/router side; the slave modport is the transmitter.
interface router_pkt_tx_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_addr;
  logic [5:0] req_len;
  logic       req_bad_par;
  logic       pay_valid;
  logic [7:0] pay_data;
  logic       pay_ready;
  logic       busy;
  logic       packet_valid;
  logic [7:0] data_out;
  logic       tx_done;
  logic       req_err;
  logic [7:0] pkt_count;

  modport master (
    output req_valid, req_addr, req_len, req_bad_par, pay_valid, pay_data, busy,
    input  req_ready, pay_ready, packet_valid, data_out, tx_done, req_err, pkt_count
  );

  modport slave (
    input  req_valid, req_addr, req_len, req_bad_par, pay_valid, pay_data, busy,
    output req_ready, pay_ready, packet_valid, data_out, tx_done, req_err, pkt_count
  );
endinterface

// File: rtl/router_pkt_tx.sv
// Packet transmitter: buffers a payload, then sends header, payload and parity
// byte to the router with busy flow control, followed by an idle gap.
module router_pkt_tx #(
  parameter int GAP_CYCLES = 1
) (
  input logic         clk,
  input logic         resetn,
  router_pkt_tx_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_HEADER, S_PAYLOAD, S_PARITY, S_GAP
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] mem [64];
  logic [5:0] idx, idx_nxt;
  logic [5:0] len_q;
  logic [1:0] addr_q;
  logic       bad_par_q;
  logic [7:0] parity, parity_nxt;
  logic [3:0] gap_cnt, gap_cnt_nxt;
  logic [7:0] data_q, data_nxt;
  logic       pv_q, pv_nxt;
  logic       done_q, done_nxt;
  logic       err_q, err_nxt;
  logic [7:0] cnt_q;
  logic       cnt_inc;
  logic       accept, store, xfer, req_bad, last_idx;

  assign bus.req_ready    = (state == S_IDLE);
  assign bus.pay_ready    = (state == S_LOAD);
  assign bus.packet_valid = pv_q;
  assign bus.data_out     = data_q;
  assign bus.tx_done      = done_q;
  assign bus.req_err      = err_q;
  assign bus.pkt_count    = cnt_q;

  assign accept   = bus.req_valid && bus.req_ready;
  assign store    = bus.pay_valid && bus.pay_ready;
  assign xfer     = !bus.busy &&
                    ((state == S_HEADER) || (state == S_PAYLOAD) || (state == S_PARITY));
  assign req_bad  = (bus.req_addr == 2'd3) || (bus.req_len == 6'd0);
  assign last_idx = (idx == len_q - 6'd1);

  // Output registers are loaded on the edge that enters the state presenting them,
  // so data_out always shows the byte that the next busy=0 edge transfers.
  always_comb begin
    state_nxt   = state;
    idx_nxt     = idx;
    parity_nxt  = parity;
    gap_cnt_nxt = gap_cnt;
    data_nxt    = data_q;
    pv_nxt      = pv_q;
    done_nxt    = 1'b0;
    err_nxt     = 1'b0;
    cnt_inc     = 1'b0;
    case (state)
      S_IDLE: begin
        data_nxt = 8'd0;
        pv_nxt   = 1'b0;
        if (accept) begin
          parity_nxt = 8'd0;
          idx_nxt    = 6'd0;
          if (req_bad) err_nxt = 1'b1;
          else         state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (store) begin
          if (last_idx) begin
            state_nxt  = S_HEADER;
            idx_nxt    = 6'd0;
            parity_nxt = parity ^ bus.pay_data ^ {len_q, addr_q};
            data_nxt   = {len_q, addr_q};
            pv_nxt     = 1'b1;
          end else begin
            idx_nxt    = idx + 6'd1;
            parity_nxt = parity ^ bus.pay_data;
          end
        end
      end
      S_HEADER: begin
        if (xfer) begin
          state_nxt = S_PAYLOAD;
          data_nxt  = mem[6'd0];
          pv_nxt    = 1'b1;
        end
      end
      S_PAYLOAD: begin
        if (xfer) begin
          if (last_idx) begin
            state_nxt = S_PARITY;
            data_nxt  = bad_par_q ? ~parity : parity;
            pv_nxt    = 1'b0;
          end else begin
            idx_nxt  = idx + 6'd1;
            data_nxt = mem[idx + 6'd1];
          end
        end
      end
      S_PARITY: begin
        if (xfer) begin
          state_nxt   = S_GAP;
          data_nxt    = 8'd0;
          pv_nxt      = 1'b0;
          done_nxt    = 1'b1;
          cnt_inc     = 1'b1;
          gap_cnt_nxt = 4'd0;
        end
      end
      S_GAP: begin
        data_nxt = 8'd0;
        pv_nxt   = 1'b0;
        if (gap_cnt == 4'(GAP_CYCLES - 1)) state_nxt = S_IDLE;
        else                               gap_cnt_nxt = gap_cnt + 4'd1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= S_IDLE;
      idx     <= 6'd0;
      parity  <= 8'd0;
      gap_cnt <= 4'd0;
      data_q  <= 8'd0;
      pv_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      parity  <= parity_nxt;
      gap_cnt <= gap_cnt_nxt;
      data_q  <= data_nxt;
      pv_q    <= pv_nxt;
      done_q  <= done_nxt;
      err_q   <= err_nxt;
      if (cnt_inc) cnt_q <= cnt_q + 8'd1;
    end
  end

  // Request fields and payload storage carry no reset; they are always written before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      len_q     <= bus.req_len;
      addr_q    <= bus.req_addr;
      bad_par_q <= bus.req_bad_par;
    end
    if (store) mem[idx] <= bus.pay_data;
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed scoreboard bench for router_pkt_tx: stimulus pushes expected bytes,
// a negedge monitor pops and compares on every transfer and parity completion.
module tb_router_pkt_tx;
  localparam int GAP = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  router_pkt_tx_if bus();

  router_pkt_tx #(.GAP_CYCLES(GAP)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int total = 0;
  int passed = 0;
  logic [7:0] byte_q[$];
  logic [7:0] par_q[$];
  int err_cnt = 0;
  int done_cnt = 0;
  int hold22 = 0;
  int xfer_cnt = 0;
  logic [7:0] prev_data = 8'd0;
  logic       prev_pv = 1'b0;
  logic [7:0] pay_buf [64];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    total++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // Monitor: a byte moves on the next rising edge when packet_valid=1 and busy=0;
  // the parity byte is the one presented in the cycle before tx_done.
  always @(negedge clk) begin
    if (resetn) begin
      if (bus.packet_valid && !bus.busy) begin
        xfer_cnt++;
        if (byte_q.size() == 0) fail_now("unexpected_byte");
        else check("byte", {24'd0, bus.data_out}, {24'd0, byte_q.pop_front()});
      end
      if (bus.tx_done) begin
        done_cnt++;
        if (par_q.size() == 0) fail_now("unexpected_parity");
        else check("parity_pv_data", {23'd0, prev_pv, prev_data}, {24'd0, par_q.pop_front()});
      end
      if (bus.req_err) err_cnt++;
      if (bus.packet_valid && bus.data_out == 8'h22) hold22++;
    end
    prev_data = bus.data_out;
    prev_pv   = bus.packet_valid;
  end

  task automatic send_req(input logic [1:0] a, input logic [5:0] l, input logic b);
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 500) begin @(negedge clk); n++; end
    if (!bus.req_ready) fail_now("req_ready_timeout");
    bus.req_valid   = 1'b1;
    bus.req_addr    = a;
    bus.req_len     = l;
    bus.req_bad_par = b;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [1:0] a, input logic [5:0] l, input logic b,
                          input logic [7:0] hdr, input logic [7:0] par);
    send_req(a, l, b);
    byte_q.push_back(hdr);
    for (int i = 0; i < int'(l); i++) byte_q.push_back(pay_buf[i]);
    par_q.push_back(par);
    for (int i = 0; i < int'(l); i++) begin
      int n = 0;
      while (!bus.pay_ready && n < 500) begin @(negedge clk); n++; end
      if (!bus.pay_ready) fail_now("pay_ready_timeout");
      bus.pay_valid = 1'b1;
      bus.pay_data  = pay_buf[i];
      @(negedge clk);
      bus.pay_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int n = 0;
    int g = 0;
    while (!bus.tx_done && n < 2000) begin @(negedge clk); n++; end
    if (!bus.tx_done) begin
      fail_now("tx_done_timeout");
    end else begin
      check("gap_pv_data", {23'd0, bus.packet_valid, bus.data_out}, 32'd0);
      while (!bus.req_ready && g < 50) begin @(negedge clk); g++; end
      check("gap_cycles", g, GAP);
    end
  endtask

  task automatic busy_pulse();
    int n = 0;
    @(posedge clk); #1;
    while (!(bus.packet_valid && bus.data_out == 8'h22) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 500) fail_now("busy_trigger_timeout");
    bus.busy = 1'b1;
    repeat (4) @(posedge clk);
    #1 bus.busy = 1'b0;
  endtask

  initial begin
    int e0, x0, d0, n;
    bus.req_valid = 1'b0; bus.req_addr = 2'd0; bus.req_len = 6'd0; bus.req_bad_par = 1'b0;
    bus.pay_valid = 1'b0; bus.pay_data = 8'd0; bus.busy = 1'b0;
    for (int i = 0; i < 64; i++) pay_buf[i] = 8'd0;

    repeat (3) @(negedge clk);
    check("rst_pv", {31'd0, bus.packet_valid}, 32'd0);
    check("rst_data", {24'd0, bus.data_out}, 32'd0);
    check("rst_done_err", {30'd0, bus.tx_done, bus.req_err}, 32'd0);
    check("rst_count", {24'd0, bus.pkt_count}, 32'd0);
    check("rst_pay_ready", {31'd0, bus.pay_ready}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);
    check("idle_req_ready", {31'd0, bus.req_ready}, 32'd1);

    // addr=1 len=3: header 0x0D, parity 0x0D^0x11^0x22^0x33 = 0x0D
    pay_buf[0] = 8'h11; pay_buf[1] = 8'h22; pay_buf[2] = 8'h33;
    send_pkt(2'd1, 6'd3, 1'b0, 8'h0D, 8'h0D);
    wait_done();
    check("count_after_1", {24'd0, bus.pkt_count}, 32'd1);
    check("done_once", done_cnt, 1);

    // Same packet with busy held four cycles on 0x22
    hold22 = 0;
    fork
      send_pkt(2'd1, 6'd3, 1'b0, 8'h0D, 8'h0D);
      busy_pulse();
    join
    wait_done();
    check("hold_0x22_cycles", hold22, 5);
    check("count_after_2", {24'd0, bus.pkt_count}, 32'd2);

    // Error-injected parity: ~0x0D = 0xF2
    send_pkt(2'd1, 6'd3, 1'b1, 8'h0D, 8'hF2);
    wait_done();
    check("count_after_3", {24'd0, bus.pkt_count}, 32'd3);

    // Rejected requests
    e0 = err_cnt; x0 = xfer_cnt;
    send_req(2'd3, 6'd5, 1'b0);
    send_req(2'd0, 6'd0, 1'b0);
    repeat (5) @(negedge clk);
    check("reject_err_pulses", err_cnt - e0, 2);
    check("reject_no_bytes", xfer_cnt - x0, 0);
    check("reject_count", {24'd0, bus.pkt_count}, 32'd3);
    check("reject_idle", {31'd0, bus.req_ready}, 32'd1);

    // addr=2 len=63 payload 0..62: header 0xFE, parity 0xFE^0x3F = 0xC1
    for (int i = 0; i < 63; i++) pay_buf[i] = 8'(i);
    send_pkt(2'd2, 6'd63, 1'b0, 8'hFE, 8'hC1);
    wait_done();
    check("count_after_63", {24'd0, bus.pkt_count}, 32'd4);
    check("queues_drained", byte_q.size() + par_q.size(), 0);

    // Second long packet, reset mid-payload
    send_pkt(2'd2, 6'd63, 1'b0, 8'hFE, 8'hC1);
    x0 = xfer_cnt; n = 0;
    while (xfer_cnt < x0 + 10 && n < 500) begin @(negedge clk); n++; end
    check("midpkt_progress", {31'd0, (xfer_cnt >= x0 + 10)}, 32'd1);
    #2 resetn = 1'b0;
    byte_q.delete();
    par_q.delete();
    #1;
    check("abort_pv", {31'd0, bus.packet_valid}, 32'd0);
    check("abort_data", {24'd0, bus.data_out}, 32'd0);
    check("abort_count", {24'd0, bus.pkt_count}, 32'd0);
    check("abort_pay_ready", {31'd0, bus.pay_ready}, 32'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    d0 = done_cnt; x0 = xfer_cnt;
    @(negedge clk);
    check("post_reset_idle", {31'd0, bus.req_ready}, 32'd1);
    repeat (10) @(negedge clk);
    check("post_reset_no_done", done_cnt - d0, 0);
    check("post_reset_no_bytes", xfer_cnt - x0, 0);
    check("post_reset_count", {24'd0, bus.pkt_count}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/router_pkt_tx.md
ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
REQ-001 Parameter: GAP_CYCLES, 1, idle cycles with packet_valid=0 inserted after each parity byte (legal 1..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 resetn  input  1  reset, asynchronous and active-low.
REQ-004 req_valid  input  1  packet request present.
REQ-005 req_ready  output  1  block can accept a request (high only in IDLE).
REQ-006 req_addr  input  2  destination channel, 0..2.
REQ-007 req_len  input  6  payload length in bytes, 1..63.
REQ-008 req_bad_par  input  1  when high, the parity byte of this packet is inverted (error injection).
REQ-009 pay_valid / pay_data  input  1 / 8  payload byte stream from host.
REQ-010 pay_ready  output  1  high only in LOAD while bytes remain to collect.
REQ-011 busy  input  1  router busy; no byte transfers while high.
REQ-012 packet_valid  output  1  registered; high for header and payload bytes, low for parity and idle.
REQ-013 data_out  output  8  registered byte to router.
REQ-014 tx_done  output  1  one-cycle pulse after parity byte transfer.
REQ-015 req_err  output  1  one-cycle pulse when a request is rejected.
REQ-016 pkt_count  output  8  count of packets fully sent, wraps 255->0.

Function
REQ-017 States: IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP.
REQ-018 Request handshake: transfer on rising edge with req_valid=1 and req_ready=1; addr, len, bad_par latched.
REQ-019 Rejection: accepted request with req_addr=3 or req_len=0 -> req_err pulse next cycle, stay IDLE, nothing transmitted, pkt_count unchanged.
REQ-020 Legal request: IDLE->LOAD; payload byte stored on each edge with pay_valid=1 and pay_ready=1 into 64x8 buffer at index 0..len-1.
REQ-021 LOAD->HEADER on edge storing byte len; pay_valid gaps stall LOAD indefinitely.
REQ-022 HEADER drives data_out={len,addr}, packet_valid=1 from the cycle after entry.
REQ-023 Byte transfer: occurs on each rising edge in HEADER/PAYLOAD/PARITY with busy sampled 0; while busy=1, data_out and packet_valid hold.
REQ-024 After header transfer: PAYLOAD drives buffer bytes 0..len-1 in order, packet_valid=1, one per transfer.
REQ-025 After last payload transfer: PARITY drives packet_valid=0, data_out=XOR(header, all payload), inverted bitwise if bad_par latched.
REQ-026 After parity transfer: GAP for GAP_CYCLES cycles, packet_valid=0, data_out=0; tx_done pulses first GAP cycle; pkt_count increments same edge.
REQ-027 GAP->IDLE after GAP_CYCLES; req_ready reasserts in IDLE; new request accepted first IDLE cycle.
REQ-028 Parity accumulated in an 8-bit register cleared on request accept; width never exceeds 8 bits.
REQ-029 Byte index counter 6 bits, no wrap: len=63 uses indices 0..62 exactly.
REQ-030 busy is ignored in IDLE, LOAD and GAP.

Reset
REQ-031 resetn=0 asynchronously: state=IDLE, req_ready=1 once released, pay_ready=0, packet_valid=0, data_out=0, tx_done=0, req_err=0, pkt_count=0, parity=0; buffer contents need not be cleared.
REQ-032 Reset mid-packet aborts the packet; no tx_done, no count increment; packet_valid low in the same cycle reset asserts.

Verification
REQ-033 addr=1, len=3, payload 0x11,0x22,0x33, busy=0 -> data_out 0x0D(pv=1),0x11,0x22,0x33(pv=1),0x0D(pv=0); tx_done once; pkt_count=1.
REQ-034 Same packet, busy=1 for 4 cycles during payload byte 0x22 -> 0x22 held 5 cycles, sequence and parity unchanged.
REQ-035 Same packet with req_bad_par=1 -> parity byte 0xF2.
REQ-036 Requests addr=3 len=5 and addr=0 len=0 -> req_err pulse each, packet_valid stays 0, pkt_count unchanged.
REQ-037 addr=2, len=63, payload 0..62 -> header 0xFE, 63 payload bytes in order, parity=0xFE^XOR(0..62); then resetn low mid-payload on a second packet -> outputs 0, IDLE, pkt_count=0.
